// File: rtl/kme_arb_pkg.sv
// Shared types, stream widths and the round-robin pick for the KME inbound arbiter.
package kme_arb_pkg;

  localparam int unsigned AXI_S_TID_WIDTH   = 4;
  localparam int unsigned AXI_S_DP_DWIDTH   = 64;
  localparam int unsigned AXI_S_TSTRB_WIDTH = 8;
  localparam int unsigned AXI_S_USER_WIDTH  = 8;

  // rr_pick works on a fixed-size vector; callers zero-extend and pass their real count.
  localparam int unsigned RR_MAX_REQ = 8;
  localparam int unsigned RR_IDX_W   = 3;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;

  // First set bit of valid at or above ptr, wrapping at n. Returns ptr when nothing is set.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                                  input logic [RR_IDX_W-1:0]   ptr,
                                                  input int unsigned           n);
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = (32'(ptr) + k) % n;
        if (valid[idx[RR_IDX_W-1:0]]) begin
          pick  = idx[RR_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/kme_axis_skid.sv
// Two-entry AXI-Stream register slice. The output comes straight from the head register.
module kme_axis_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign pop       = out_valid & out_ready;
  // Room exists when fewer than two entries remain after this cycle's pop.
  assign in_ready  = (count_q != 2'd2) | out_ready;
  assign push      = in_valid & in_ready;

  // Next-state for occupancy and the two data registers.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Slice state; reset empties both entries so tvalid drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/kme_ib_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing the KME inbound AXI-Stream port among requesters.
module kme_ib_stream_arbiter
  import kme_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter bit          TID_FROM_IDX = 1'b0,
  localparam int unsigned IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_tvalid,
  output logic [N_REQ-1:0]                    req_tready,
  input  logic [N_REQ-1:0]                    req_tlast,
  input  logic [N_REQ*AXI_S_TID_WIDTH-1:0]    req_tid,
  input  logic [N_REQ*AXI_S_DP_DWIDTH-1:0]    req_tdata,
  input  logic [N_REQ*AXI_S_TSTRB_WIDTH-1:0]  req_tstrb,
  input  logic [N_REQ*AXI_S_USER_WIDTH-1:0]   req_tuser,
  output logic                                kme_ib_tvalid,
  input  logic                                kme_ib_tready,
  output logic                                kme_ib_tlast,
  output logic [AXI_S_TID_WIDTH-1:0]          kme_ib_tid,
  output logic [AXI_S_DP_DWIDTH-1:0]          kme_ib_tdata,
  output logic [AXI_S_TSTRB_WIDTH-1:0]        kme_ib_tstrb,
  output logic [AXI_S_USER_WIDTH-1:0]         kme_ib_tuser,
  output logic                                arb_busy,
  output logic [IDX_W-1:0]                    arb_grant_idx,
  output logic [N_REQ-1:0]                    arb_frame_done
);

  localparam int unsigned SKID_W = AXI_S_TID_WIDTH + AXI_S_DP_DWIDTH + AXI_S_TSTRB_WIDTH +
                                   AXI_S_USER_WIDTH + 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              en_q;
  logic [IDX_W-1:0]  sel;
  logic              sel_valid, sel_last;
  logic              skid_ready, has_room, accept;
  logic [AXI_S_TID_WIDTH-1:0] beat_tid;
  logic [SKID_W-1:0] skid_in, skid_out;

  // Locked frames keep their owner; otherwise the round-robin winner is selected.
  assign sel = (state_q == LOCKED) ? grant_q
             : IDX_W'(rr_pick(RR_MAX_REQ'(req_tvalid), RR_IDX_W'(rr_ptr_q), N_REQ));

  assign sel_valid = req_tvalid[sel];
  assign sel_last  = req_tlast[sel];
  // en_q keeps every tready low while reset is asserted, independent of requester valids.
  assign has_room  = skid_ready & en_q;
  assign accept    = has_room & sel_valid;
  assign req_tready = has_room ? (N_REQ'(1) << sel) : '0;

  assign beat_tid = TID_FROM_IDX ? AXI_S_TID_WIDTH'(sel)
                                 : req_tid[sel*AXI_S_TID_WIDTH +: AXI_S_TID_WIDTH];
  assign skid_in  = {beat_tid,
                     req_tdata[sel*AXI_S_DP_DWIDTH +: AXI_S_DP_DWIDTH],
                     req_tstrb[sel*AXI_S_TSTRB_WIDTH +: AXI_S_TSTRB_WIDTH],
                     req_tuser[sel*AXI_S_USER_WIDTH +: AXI_S_USER_WIDTH],
                     sel_last};

  kme_axis_skid #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sel_valid & en_q),
    .in_ready  (skid_ready),
    .in_data   (skid_in),
    .out_valid (kme_ib_tvalid),
    .out_ready (kme_ib_tready),
    .out_data  (skid_out)
  );

  assign {kme_ib_tid, kme_ib_tdata, kme_ib_tstrb, kme_ib_tuser, kme_ib_tlast} = skid_out;
  assign arb_busy       = (state_q == LOCKED);
  assign arb_grant_idx  = grant_q;
  assign arb_frame_done = done_q;

  // Frame lock, round-robin pointer advance and frame-done pulse on each accepted beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
    if (accept) begin
      grant_d = sel;
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = (32'(sel) == N_REQ - 1) ? '0 : sel + IDX_W'(1);
        done_d   = N_REQ'(1) << sel;
      end else begin
        state_d = LOCKED;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      done_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
      en_q     <= 1'b1;
    end
  end

endmodule
